// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter.
// Optional build macro used by the top: IO_UART_THROTTLE_EN.
package mem_arbiter_pkg;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 32;
  localparam logic [1:0]  ARB_IO_HI  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT_IF  = 2'd1,
    ST_GRANT_LSB = 2'd2
  } state_e;

  // Requester ids double as bit positions in request/grant vectors
  localparam int unsigned REQ_IF  = 0;
  localparam int unsigned REQ_LSB = 1;

  localparam logic [2:0] W_BYTE = 3'd1;
  localparam logic [2:0] W_HALF = 3'd2;
  localparam logic [2:0] W_WORD = 3'd4;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin picker; on a tie the side not granted last wins.
module mem_arbiter_rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant_c
);

  logic last_lsb;

  always_comb begin
    grant_c = req;
    if (req == 2'b11) begin
      grant_c = '0;
      if (last_lsb) grant_c[REQ_IF] = 1'b1;
      else          grant_c[REQ_LSB] = 1'b1;
    end
  end

  // Reset to LSB so the fetcher wins the very first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                last_lsb <= 1'b1;
    else if (en && |req)     last_lsb <= grant_c[REQ_LSB];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the byte-serial memory controller between instruction fetch and the LSB.
// Build macro IO_UART_THROTTLE_EN holds IO stores back while the UART FIFO is full.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ARB_ADDR_W,
  parameter int unsigned DATA_W = ARB_DATA_W,
  parameter logic [1:0]  IO_HI  = ARB_IO_HI
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              uart_full,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ok,
  output logic [DATA_W-1:0] if_data,
  input  logic              lsb_req,
  input  logic              lsb_rw,
  input  logic [2:0]        lsb_width,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [DATA_W-1:0] lsb_wdata,
  output logic              lsb_ok,
  output logic [DATA_W-1:0] lsb_rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [2:0]        mem_width,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state, state_n;
  logic              mem_en_n, mem_rw_n, if_ok_n, lsb_ok_n;
  logic [2:0]        mem_width_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n, if_data_n, lsb_rdata_n, rdata_ext_c;
  logic [1:0]        req_c, grant_c;
  logic              lsb_hold_c;

`ifdef IO_UART_THROTTLE_EN
  assign lsb_hold_c = !lsb_rw && (lsb_addr[17:16] == IO_HI) && uart_full;
`else
  logic unused_uart;
  assign lsb_hold_c  = 1'b0;
  assign unused_uart = uart_full;
`endif

  // A requester still sees its old request during its ok cycle, so mask it there
  assign req_c[REQ_IF]  = if_req && !if_ok && !clear;
  assign req_c[REQ_LSB] = lsb_req && !lsb_ok && !clear && !lsb_hold_c;

  mem_arbiter_rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .en      (rdy && (state == ST_IDLE)),
    .req     (req_c),
    .grant_c (grant_c)
  );

  always_comb begin
    case (mem_width)
      W_BYTE:  rdata_ext_c = DATA_W'(mem_rdata[7:0]);
      W_HALF:  rdata_ext_c = DATA_W'(mem_rdata[15:0]);
      default: rdata_ext_c = mem_rdata;
    endcase
  end

  always_comb begin
    state_n     = state;
    mem_en_n    = mem_en;
    mem_rw_n    = mem_rw;
    mem_width_n = mem_width;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    if_data_n   = if_data;
    lsb_rdata_n = lsb_rdata;
    if_ok_n     = 1'b0;
    lsb_ok_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_c[REQ_IF]) begin
          state_n     = ST_GRANT_IF;
          mem_en_n    = 1'b1;
          mem_rw_n    = 1'b1;
          mem_width_n = W_WORD;
          mem_addr_n  = if_addr;
          mem_wdata_n = '0;
        end else if (grant_c[REQ_LSB]) begin
          state_n     = ST_GRANT_LSB;
          mem_en_n    = 1'b1;
          mem_rw_n    = lsb_rw;
          mem_width_n = lsb_width;
          mem_addr_n  = lsb_addr;
          mem_wdata_n = lsb_wdata;
        end
      end
      ST_GRANT_IF: begin
        if (!if_req || clear) begin
          state_n  = ST_IDLE;
          mem_en_n = 1'b0;
        end else if (mem_ok) begin
          state_n   = ST_IDLE;
          mem_en_n  = 1'b0;
          if_ok_n   = 1'b1;
          if_data_n = mem_rdata;
        end
      end
      ST_GRANT_LSB: begin
        // Committed stores survive a flush; loads are speculative
        if (!lsb_req || (clear && mem_rw)) begin
          state_n  = ST_IDLE;
          mem_en_n = 1'b0;
        end else if (mem_ok) begin
          state_n  = ST_IDLE;
          mem_en_n = 1'b0;
          lsb_ok_n = 1'b1;
          if (mem_rw) lsb_rdata_n = rdata_ext_c;
        end
      end
      default: begin
        state_n  = ST_IDLE;
        mem_en_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      mem_en    <= 1'b0;
      mem_rw    <= 1'b0;
      mem_width <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ok     <= 1'b0;
      if_data   <= '0;
      lsb_ok    <= 1'b0;
      lsb_rdata <= '0;
    end else if (rdy) begin
      state     <= state_n;
      mem_en    <= mem_en_n;
      mem_rw    <= mem_rw_n;
      mem_width <= mem_width_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      if_ok     <= if_ok_n;
      if_data   <= if_data_n;
      lsb_ok    <= lsb_ok_n;
      lsb_rdata <= lsb_rdata_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Throttle scenario is compiled only when IO_UART_THROTTLE_EN is defined.
module tb_mem_arbiter;

  logic        clk = 1'b0, rst = 1'b0, rdy = 1'b1, clear = 1'b0, uart_full = 1'b0;
  logic        if_req = 1'b0, if_ok;
  logic [31:0] if_addr = '0, if_data;
  logic        lsb_req = 1'b0, lsb_rw = 1'b1, lsb_ok;
  logic [2:0]  lsb_width = 3'd4;
  logic [31:0] lsb_addr = '0, lsb_wdata = '0, lsb_rdata;
  logic        mem_en, mem_rw, mem_ok = 1'b0;
  logic [2:0]  mem_width;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;

  int checks = 0;
  int failures = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .uart_full(uart_full),
    .if_req(if_req), .if_addr(if_addr), .if_ok(if_ok), .if_data(if_data),
    .lsb_req(lsb_req), .lsb_rw(lsb_rw), .lsb_width(lsb_width), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_ok(lsb_ok), .lsb_rdata(lsb_rdata),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_width(mem_width), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ok(mem_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_grant(input logic [31:0] rdata);
    mem_ok = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    checks++; if ({mem_en, if_ok, lsb_ok, mem_rw} !== 4'b0) begin failures++; $display("FAIL reset_ctl got=%b exp=0000", {mem_en, if_ok, lsb_ok, mem_rw}); end
    checks++; if ({mem_addr, mem_wdata, if_data, lsb_rdata} !== 128'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, if_data, lsb_rdata}); end
    rst = 1'b1;
    tick();
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL idle_after_reset got=%b exp=0", mem_en); end
  endtask

  task automatic test_single_fetch();
    int en_cnt;
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    en_cnt = mem_en ? 1 : 0;
    checks++; if ({mem_en, mem_rw, mem_width} !== {1'b1, 1'b1, 3'd4}) begin failures++; $display("FAIL fetch_grant got=%b%b%0d exp=114", mem_en, mem_rw, mem_width); end
    checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL fetch_addr got=%h exp=00000100", mem_addr); end
    if_addr = 32'hFFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_en) en_cnt++;
    end
    checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL fetch_latch got=%h exp=00000100", mem_addr); end
    finish_grant(32'h00A00093);
    checks++; if (en_cnt != 5) begin failures++; $display("FAIL fetch_en_cycles got=%0d exp=5", en_cnt); end
    checks++; if ({mem_en, if_ok} !== 2'b01) begin failures++; $display("FAIL fetch_ok got=%b exp=01", {mem_en, if_ok}); end
    checks++; if (if_data !== 32'h00A00093) begin failures++; $display("FAIL fetch_data got=%h exp=00a00093", if_data); end
    if_req = 1'b0;
    tick();
    checks++; if ({mem_en, if_ok} !== 2'b00) begin failures++; $display("FAIL fetch_ok_pulse got=%b exp=00", {mem_en, if_ok}); end
  endtask

  task automatic test_tie();
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h104;
    lsb_req = 1'b1; lsb_rw = 1'b1; lsb_width = 3'd1; lsb_addr = 32'h200;
    tick();
    rst = 1'b1;
    tick();
    checks++; if ({mem_en, mem_addr} !== {1'b1, 32'h104}) begin failures++; $display("FAIL tie_first_if got=%b/%h exp=1/00000104", mem_en, mem_addr); end
    finish_grant(32'h11111111);
    checks++; if ({mem_en, if_ok, lsb_ok} !== 3'b010) begin failures++; $display("FAIL tie_if_ok_gap got=%b exp=010", {mem_en, if_ok, lsb_ok}); end
    tick();
    checks++; if ({mem_en, mem_addr, mem_width} !== {1'b1, 32'h200, 3'd1}) begin failures++; $display("FAIL tie_then_lsb got=%b/%h/%0d exp=1/00000200/1", mem_en, mem_addr, mem_width); end
    finish_grant(32'hFFFFFF85);
    checks++; if ({mem_en, lsb_ok} !== 2'b01) begin failures++; $display("FAIL tie_lsb_ok got=%b exp=01", {mem_en, lsb_ok}); end
    checks++; if (lsb_rdata !== 32'h00000085) begin failures++; $display("FAIL byte_load got=%h exp=00000085", lsb_rdata); end
    if_req = 1'b0; lsb_req = 1'b0;
    tick();
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL tie_idle got=%b exp=0", mem_en); end
    if_req = 1'b1; lsb_req = 1'b1;
    tick();
    checks++; if (mem_addr !== 32'h104) begin failures++; $display("FAIL tie2_if got=%h exp=00000104", mem_addr); end
    finish_grant(32'h22222222);
    if_req = 1'b0; lsb_req = 1'b0;
    tick();
    if_req = 1'b1; lsb_req = 1'b1;
    tick();
    checks++; if ({mem_en, mem_addr} !== {1'b1, 32'h200}) begin failures++; $display("FAIL tie3_lsb got=%b/%h exp=1/00000200", mem_en, mem_addr); end
    finish_grant(32'h33333333);
    if_req = 1'b0; lsb_req = 1'b0;
    tick();
  endtask

  task automatic test_load_widths();
    logic [2:0]  w   [3] = '{3'd1, 3'd2, 3'd4};
    logic [31:0] exp [3] = '{32'h0000000D, 32'h0000F00D, 32'hCAFEF00D};
    for (int i = 0; i < 3; i++) begin
      lsb_req = 1'b1; lsb_rw = 1'b1; lsb_width = w[i]; lsb_addr = 32'h700;
      tick();
      checks++; if (mem_width !== w[i]) begin failures++; $display("FAIL load_width%0d got=%0d exp=%0d", i, mem_width, w[i]); end
      finish_grant(32'hCAFEF00D);
      checks++; if ({lsb_ok, lsb_rdata} !== {1'b1, exp[i]}) begin failures++; $display("FAIL load_zext%0d got=%b/%h exp=1/%h", i, lsb_ok, lsb_rdata, exp[i]); end
      lsb_req = 1'b0;
      tick();
    end
  endtask

  task automatic test_flush_fetch();
    if_req = 1'b1; if_addr = 32'h400; clear = 1'b1;
    tick();
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL clear_idle_nogrant got=%b exp=0", mem_en); end
    clear = 1'b0;
    tick();
    checks++; if ({mem_en, mem_addr} !== {1'b1, 32'h400}) begin failures++; $display("FAIL fetch_regrant got=%b/%h exp=1/00000400", mem_en, mem_addr); end
    clear = 1'b1; mem_ok = 1'b1; mem_rdata = 32'h55555555;
    tick();
    checks++; if ({mem_en, if_ok} !== 2'b00) begin failures++; $display("FAIL clear_fetch_abort got=%b exp=00", {mem_en, if_ok}); end
    clear = 1'b0; mem_ok = 1'b0; if_req = 1'b0;
    tick();
    checks++; if ({mem_en, if_ok} !== 2'b00) begin failures++; $display("FAIL clear_fetch_no_ok got=%b exp=00", {mem_en, if_ok}); end
  endtask

  task automatic test_flush_store();
    lsb_req = 1'b1; lsb_rw = 1'b0; lsb_width = 3'd4; lsb_addr = 32'h300; lsb_wdata = 32'hDEADBEEF;
    tick();
    checks++; if ({mem_en, mem_rw, mem_addr, mem_wdata} !== {2'b10, 32'h300, 32'hDEADBEEF}) begin failures++; $display("FAIL store_grant got=%b%b/%h/%h exp=10/00000300/deadbeef", mem_en, mem_rw, mem_addr, mem_wdata); end
    clear = 1'b1;
    tick();
    checks++; if (mem_en !== 1'b1) begin failures++; $display("FAIL store_survives_clear got=%b exp=1", mem_en); end
    clear = 1'b0;
    finish_grant(32'h0);
    checks++; if ({mem_en, lsb_ok} !== 2'b01) begin failures++; $display("FAIL store_ok got=%b exp=01", {mem_en, lsb_ok}); end
    lsb_req = 1'b0; lsb_rw = 1'b1;
    tick();
    checks++; if (lsb_ok !== 1'b0) begin failures++; $display("FAIL store_ok_pulse got=%b exp=0", lsb_ok); end
  endtask

  task automatic test_withdraw();
    lsb_req = 1'b1; lsb_rw = 1'b1; lsb_width = 3'd4; lsb_addr = 32'h600;
    tick();
    lsb_req = 1'b0;
    tick();
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL withdraw_abort got=%b exp=0", mem_en); end
    finish_grant(32'h12121212);
    checks++; if ({mem_en, lsb_ok} !== 2'b00) begin failures++; $display("FAIL withdraw_no_ok got=%b exp=00", {mem_en, lsb_ok}); end
  endtask

  task automatic test_rdy_hold();
    if_req = 1'b1; if_addr = 32'h500;
    tick();
    finish_grant(32'h12345678);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({mem_en, if_ok, if_data} !== {2'b01, 32'h12345678}) begin failures++; $display("FAIL rdy_frozen%0d got=%b%b/%h exp=01/12345678", i, mem_en, if_ok, if_data); end
    end
    rdy = 1'b1;
    checks++; if (if_ok !== 1'b1) begin failures++; $display("FAIL rdy_ok_pending got=%b exp=1", if_ok); end
    if_req = 1'b0;
    tick();
    checks++; if ({mem_en, if_ok} !== 2'b00) begin failures++; $display("FAIL rdy_ok_once got=%b exp=00", {mem_en, if_ok}); end
  endtask

`ifdef IO_UART_THROTTLE_EN
  task automatic test_uart_throttle();
    uart_full = 1'b1;
    lsb_req = 1'b1; lsb_rw = 1'b0; lsb_width = 3'd1; lsb_addr = 32'h30000; lsb_wdata = 32'h41;
    if_req = 1'b1; if_addr = 32'h800;
    tick();
    checks++; if ({mem_en, mem_addr} !== {1'b1, 32'h800}) begin failures++; $display("FAIL throttle_if_first got=%b/%h exp=1/00000800", mem_en, mem_addr); end
    finish_grant(32'h13);
    if_req = 1'b0;
    tick();
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL throttle_store_held got=%b exp=0", mem_en); end
    uart_full = 1'b0;
    tick();
    checks++; if ({mem_en, mem_addr} !== {1'b1, 32'h30000}) begin failures++; $display("FAIL throttle_store_grant got=%b/%h exp=1/00030000", mem_en, mem_addr); end
    finish_grant(32'h0);
    lsb_req = 1'b0; lsb_rw = 1'b1;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_fetch();
    test_tie();
    test_load_widths();
    test_flush_fetch();
    test_flush_store();
    test_withdraw();
    test_rdy_hold();
`ifdef IO_UART_THROTTLE_EN
    test_uart_throttle();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-serial memory controller between the instruction fetcher (IF) and the load/store buffer (LSB).
- Latches one request at a time, drives the controller's request interface, and routes the response back to the owner.
- Round-robin fairness; flush cancels speculative traffic (fetches, loads) but never a committed store.
- Sits between IF/LSB and the memory controller.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data/instruction width
IO_HI, 2'b11, value of addr[17:16] that marks memory-mapped IO

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
rdy  in  1  global ready; when low, all state holds
clear  in  1  flush from ROB (mispredict)
uart_full  in  1  UART output FIFO full
if_req  in  1  fetch request, held until if_ok
if_addr  in  ADDR_W  fetch address
if_ok  out  1  one-cycle pulse, if_data valid
if_data  out  DATA_W  fetched instruction
lsb_req  in  1  load/store request, held until lsb_ok
lsb_rw  in  1  1 = read, 0 = write
lsb_width  in  3  bytes: 1, 2 or 4
lsb_addr  in  ADDR_W  access address
lsb_wdata  in  DATA_W  store data, low bytes used
lsb_ok  out  1  one-cycle pulse, done (lsb_rdata valid on reads)
lsb_rdata  out  DATA_W  load data, zero-extended to width
mem_en  out  1  request to controller
mem_rw  out  1  1 = read, 0 = write
mem_width  out  3  bytes
mem_addr  out  ADDR_W  address
mem_wdata  out  DATA_W  store data
mem_ok  in  1  controller completion pulse
mem_rdata  in  DATA_W  controller read data

Behaviour:
- Reset (rst low, async): state IDLE, last_grant = LSB (IF wins the first tie). All outputs 0.
- States:
  - IDLE: mem_en = 0. Sample requests (masked by clear). Grant next cycle; mem_* and mem_en are registered.
  - GRANT_IF: mem_en = 1, mem_rw = 1, mem_width = 4, mem_addr = latched if_addr.
  - GRANT_LSB: mem_en = 1, mem_* from the latched LSB request.
- Arbitration in IDLE:
  - Only one requester: grant it.
  - Both requesting: grant the one that is not last_grant.
  - last_grant is updated on grant.
- Completion:
  - In GRANT_x with mem_ok = 1: capture mem_rdata and drop mem_en next cycle.
  - Pulse x_ok for exactly one cycle with captured data (1-cycle latency after mem_ok); return to IDLE.
  - mem_en is guaranteed low for at least one cycle between consecutive grants.
- Read data: lsb_rdata upper bytes beyond lsb_width are forced to 0.
- Latching: address, data, width and rw are latched at grant. Later requester changes are ignored until ok.
- Requester withdrawal mid-grant (req low before ok): abort, mem_en low next cycle, IDLE, no ok pulse.
- clear:
  - In GRANT_IF or GRANT_LSB-read: abort as above; the ok pulse is suppressed even if mem_ok coincides.
  - In GRANT_LSB-write: ignored; the store completes and lsb_ok pulses.
  - In IDLE: no grant issued that cycle.
- Simultaneous mem_ok and clear on a read: clear wins (no ok).
- Grant of a new request in the same cycle an ok pulse is issued is allowed.
- rdy low: every register holds, including a pending ok pulse, which is issued after rdy returns.

Optional Feature:
- Macro IO_UART_THROTTLE_EN.
- Defined: an LSB write with lsb_addr[17:16] == IO_HI is not granted while uart_full = 1. IF may be granted meanwhile; the LSB is granted in the first IDLE cycle with uart_full = 0, subject to round-robin. uart_full is ignored once granted.
- Not defined: uart_full is unused; IO writes arbitrate normally.

Decomposition:
- Shared package/define file: state encodings (IDLE, GRANT_IF, GRANT_LSB), requester ids, width codes (1/2/4), IO_HI, ADDR_W/DATA_W macros.
- One natural sub-module, rr_arb2: two-requester round-robin picker with last_grant register and enable.

Test Plan:
- Single fetch: if_req, if_addr = 0x100, mem_ok after 5 cycles with 0x00A00093 -> mem_en high for 5 cycles, mem_width = 4, if_ok 1 cycle later with if_data = 0x00A00093.
- Tie: if_req and lsb_req (load width 1, 0x200) both high from reset -> IF granted first, LSB next, with ≥1 idle cycle between. Repeat the tie -> IF and LSB alternate.
- Byte load: mem_rdata = 0xFFFFFF85, width 1 -> lsb_rdata = 0x00000085.
- Flush: clear during a fetch grant -> mem_en low next cycle, no if_ok. clear during store (addr 0x300, 0xDEADBEEF, width 4) -> store completes, lsb_ok pulses.
- rdy low for 3 cycles in the cycle after mem_ok -> outputs frozen; ok pulses once after rdy rises.
- With IO_UART_THROTTLE_EN: store to 0x30000 while uart_full = 1 and a pending fetch -> fetch granted, store waits. Drop uart_full -> store granted next IDLE.
